alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Registered decode stage that produces the ALU's operation select and operand controls from a 32-bit RV32 instruction word; it is the producer side of the ALU select interface.
- Sits between instruction fetch and the ALU/register-file read.
- Valid/ready handshake on both sides.
- Two-entry skid buffer gives full throughput with registered `in_ready`.

Parameters:
- `INSTR_WIDTH`, 32, instruction and PC width. Only 32 is supported.
- `ALUSEL_W`, 4, width of the ALU select output.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `in_valid` input 1: instruction offered.
- `in_ready` output 1: stage can accept.
- `in_instr` input 32: instruction word.
- `in_pc` input 32: PC of the instruction.
- `out_valid` output 1: decoded bundle valid.
- `out_ready` input 1: downstream accepts.
- `out_alu_sel` output 4: ALU operation select.
- `out_op1_sel` output 2: 0 = rs1, 1 = pc, 2 = zero.
- `out_op2_sel` output 1: 0 = rs2, 1 = imm.
- `out_imm` output 32: sign-extended immediate.
- `out_rs1` output 5, `out_rs2` output 5, `out_rd` output 5: register indices.
- `out_reg_write` output 1: rd write enable.
- `out_illegal` output 1: unsupported encoding.
- `out_pc` output 32: PC passthrough.

Behaviour:
- Reset (`rst_n` = 0 at posedge): `out_valid` = 0, skid empty, `in_ready` = 1. All bundle outputs = 0. Reset mid-transfer drops both entries with no partial output.
- Transfer occurs when valid & ready are both high at a posedge. Decode latency is 1 cycle: an instruction accepted at edge N appears on `out_*` after edge N. Throughput is 1 per cycle while `out_ready` = 1.
- Storage: main register plus one skid register. `in_ready` is a register output and equals NOT skid_full.
  - Accept while main empty or draining this cycle: load main.
  - Accept while main held (`out_valid` & ~`out_ready`): load skid, which lowers `in_ready` next cycle.
  - On drain with skid full: skid moves to main. Order is strictly preserved.
  - Simultaneous accept and drain with skid full cannot occur, because `in_ready` = 0.
- `out_*` must stay stable while `out_valid` & ~`out_ready`.
- Decode (opcode[6:0], funct3[14:12], funct7[31:25]); `out_alu_sel` values:
  - R 0110011: ADD 0000 (f3 000, f7 0000000), SUB 0001 (f3 000, f7 0100000), AND 0010 (111), OR 0011 (110), XOR 0100 (100), SLL 0101 (001, f7 0), SRL 0110 (101, f7 0).
  - R controls: op1 = rs1, op2 = rs2, reg_write = 1.
  - I 0010011: ADDI 0111 (000), SLLI 1000 (001, f7 0), SRLI 1001 (101, f7 0).
  - I controls: op1 = rs1, op2 = imm, reg_write = 1. For SLLI/SRLI, `out_imm` = zero-extended shamt[24:20].
  - LUI 0110111: 1010, op1 = zero, op2 = imm, U-imm = {instr[31:12], 12'b0}.
  - AUIPC 0010111: 1011, op1 = pc, op2 = imm, U-imm.
  - JAL 1101111: 1100, op1 = pc, op2 = imm, J-imm sign-extended.
  - JALR 1100111 (f3 000): 1101, op1 = rs1, op2 = imm, I-imm.
  - rs1/rs2/rd are always the raw fields [19:15]/[24:20]/[11:7].
- Illegal: any other opcode/funct combination (SLT*, SRA*, SLTI*, XORI/ORI/ANDI, loads, stores, branches, bad funct7). Illegal instructions still flow through the handshake with `out_illegal` = 1, `out_alu_sel` = 0000, `out_reg_write` = 0, `out_imm` = 0.
- `out_reg_write` is forced to 0 when rd = 0.

Optional Feature:
- Macro `ALU_DECODE_PERF_EN`.
- When defined:
  - Adds output ports `perf_decoded` 16 and `perf_illegal` 16.
  - Each counter increments on every output transfer (`out_valid` & `out_ready`); `perf_illegal` only when `out_illegal` = 1.
  - Counters wrap at 16'hFFFF → 0 and reset to 0.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- `in_instr` = 32'h40208033 (sub x0? use rd = 1: 32'h402080B3), `out_ready` = 1 → one cycle later: `out_alu_sel` = 0001, op2_sel = 0, rd = 1, rs1 = 1, rs2 = 2, reg_write = 1.
- LUI 32'h123450B7, pc = 32'h100 → alu_sel = 1010, imm = 32'h12345000, op1_sel = 2. Next, AUIPC 32'hFFFFF097 → alu_sel = 1011, imm = 32'hFFFFF000, op1_sel = 1, `out_pc` = 32'h104.
- JAL 32'hFF5FF0EF → alu_sel = 1100, imm = 32'hFFFFFFF4, op1_sel = 1. SRAI 32'h4030D093 → illegal = 1, alu_sel = 0000, reg_write = 0.
- Backpressure: stream ADDI x1..x4 with `out_ready` = 0 for 3 cycles → `in_ready` drops after the second accept, `out_*` stays stable on ADDI x1, and all four emerge in order after release with no drop or duplicate.
- Assert `rst_n` = 0 with both entries full → next cycle `out_valid` = 0, `in_ready` = 1, and the following instruction decodes normally.
- With `ALU_DECODE_PERF_EN`: 65537 transfers, 3 of them illegal → `perf_decoded` = 1 (wrapped), `perf_illegal` = 3.

Source files
------------

// File: rtl/alu_decode_stage.sv
// Registered RV32 decode stage driving the ALU select interface, with a two-entry
// (main + skid) buffer so in_ready is a flop. Optional counters: ALU_DECODE_PERF_EN.
module alu_decode_stage #(
  parameter int INSTR_WIDTH = 32,
  parameter int ALUSEL_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [INSTR_WIDTH-1:0] in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALUSEL_W-1:0]    out_alu_sel,
  output logic [1:0]             out_op1_sel,
  output logic                   out_op2_sel,
  output logic [INSTR_WIDTH-1:0] out_imm,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic                   out_reg_write,
  output logic                   out_illegal,
  output logic [INSTR_WIDTH-1:0] out_pc
`ifdef ALU_DECODE_PERF_EN
  ,
  output logic [15:0]            perf_decoded,
  output logic [15:0]            perf_illegal
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [ALUSEL_W-1:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_ADDI  = 4'b0111,
    ALU_SLLI  = 4'b1000,
    ALU_SRLI  = 4'b1001,
    ALU_LUI   = 4'b1010,
    ALU_AUIPC = 4'b1011,
    ALU_JAL   = 4'b1100,
    ALU_JALR  = 4'b1101
  } alu_sel_e;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_e;

  localparam logic OP2_RS2 = 1'b0;
  localparam logic OP2_IMM = 1'b1;

  typedef struct packed {
    logic [ALUSEL_W-1:0]    alu_sel;
    logic [1:0]             op1_sel;
    logic                   op2_sel;
    logic [INSTR_WIDTH-1:0] imm;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic                   reg_write;
    logic                   illegal;
    logic [INSTR_WIDTH-1:0] pc;
  } bundle_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [6:0]             funct7;
  logic [INSTR_WIDTH-1:0] imm_i;
  logic [INSTR_WIDTH-1:0] imm_u;
  logic [INSTR_WIDTH-1:0] imm_j;
  logic [INSTR_WIDTH-1:0] imm_shamt;
  logic                   legal;
  bundle_t                dec;

  assign opcode    = in_instr[6:0];
  assign funct3    = in_instr[14:12];
  assign funct7    = in_instr[31:25];
  assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u     = {in_instr[31:12], 12'b0};
  assign imm_j     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
  assign imm_shamt = {27'b0, in_instr[24:20]};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps the decode free of inferred latches.
  always_comb begin
    dec           = '0;
    legal         = 1'b1;
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.rd        = in_instr[11:7];
    dec.pc        = in_pc;
    dec.reg_write = 1'b1;

    case (opcode)
      OPC_OP: begin
        dec.op1_sel = OP1_RS1;
        dec.op2_sel = OP2_RS2;
        if (funct7 == F7_ZERO) begin
          case (funct3)
            3'b000:  dec.alu_sel = ALU_ADD;
            3'b111:  dec.alu_sel = ALU_AND;
            3'b110:  dec.alu_sel = ALU_OR;
            3'b100:  dec.alu_sel = ALU_XOR;
            3'b001:  dec.alu_sel = ALU_SLL;
            3'b101:  dec.alu_sel = ALU_SRL;
            default: legal       = 1'b0;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.alu_sel = ALU_SUB;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec.op1_sel = OP1_RS1;
        dec.op2_sel = OP2_IMM;
        if (funct3 == 3'b000) begin
          dec.alu_sel = ALU_ADDI;
          dec.imm     = imm_i;
        end else if (funct3 == 3'b001 && funct7 == F7_ZERO) begin
          dec.alu_sel = ALU_SLLI;
          dec.imm     = imm_shamt;
        end else if (funct3 == 3'b101 && funct7 == F7_ZERO) begin
          dec.alu_sel = ALU_SRLI;
          dec.imm     = imm_shamt;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec.alu_sel = ALU_LUI;
        dec.op1_sel = OP1_ZERO;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_u;
      end
      OPC_AUIPC: begin
        dec.alu_sel = ALU_AUIPC;
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_u;
      end
      OPC_JAL: begin
        dec.alu_sel = ALU_JAL;
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_j;
      end
      OPC_JALR: begin
        dec.alu_sel = ALU_JALR;
        dec.op1_sel = OP1_RS1;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_i;
        if (funct3 != 3'b000) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase

    // Illegal words still travel the pipe, but carry no operation or write.
    if (!legal) begin
      dec.alu_sel   = '0;
      dec.op1_sel   = '0;
      dec.op2_sel   = 1'b0;
      dec.imm       = '0;
      dec.reg_write = 1'b0;
      dec.illegal   = 1'b1;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Main + skid storage
  // ---------------------------------------------------------------------------
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    in_ready_q, in_ready_d;
  logic    in_fire, out_fire, main_free;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = main_valid_q & out_ready;
  assign main_free = ~main_valid_q | out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (skid_valid_q) begin
      // in_ready is low here, so only the skid-to-main move can happen.
      if (out_ready) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (main_free) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values; both bundle registers are reset because the outputs must
  // read zero after reset, not just be flagged invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_valid_q;
  assign out_alu_sel   = main_q.alu_sel;
  assign out_op1_sel   = main_q.op1_sel;
  assign out_op2_sel   = main_q.op2_sel;
  assign out_imm       = main_q.imm;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.reg_write;
  assign out_illegal   = main_q.illegal;
  assign out_pc        = main_q.pc;

`ifdef ALU_DECODE_PERF_EN
  logic [15:0] perf_decoded_q, perf_decoded_d;
  logic [15:0] perf_illegal_q, perf_illegal_d;

  // Counters wrap naturally at 16 bits.
  always_comb begin
    perf_decoded_d = perf_decoded_q;
    perf_illegal_d = perf_illegal_q;
    if (out_fire) begin
      perf_decoded_d = perf_decoded_q + 16'd1;
      if (main_q.illegal) perf_illegal_d = perf_illegal_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_decoded_q <= '0;
      perf_illegal_q <= '0;
    end else begin
      perf_decoded_q <= perf_decoded_d;
      perf_illegal_q <= perf_illegal_d;
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed steps from the decode table,
// backpressure and reset cases, then a random stream against a reference model.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_sel;
  logic [1:0]  out_op1_sel;
  logic        out_op2_sel;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_write;
  logic        out_illegal;
  logic [31:0] out_pc;
`ifdef ALU_DECODE_PERF_EN
  logic [15:0] perf_decoded, perf_illegal;
`endif

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_sel(out_alu_sel), .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal), .out_pc(out_pc)
`ifdef ALU_DECODE_PERF_EN
    , .perf_decoded(perf_decoded), .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  alu_sel;
    logic [1:0]  op1;
    logic        op2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    logic [31:0] pc;
  } bundle_t;

  int          checks   = 0;
  int          failures = 0;
  bundle_t     exp_q[$];
  int          n_out    = 0;
  logic [15:0] m_dec    = 0;
  logic [15:0] m_ill    = 0;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t cur_out();
    bundle_t b;
    b = '{out_alu_sel, out_op1_sel, out_op2_sel, out_imm, out_rs1, out_rs2,
          out_rd, out_reg_write, out_illegal, out_pc};
    return b;
  endfunction

  // Reference decode written from the instruction table by mnemonic.
  function automatic bundle_t ref_decode(logic [31:0] w, logic [31:0] pc);
    bundle_t     b;
    string       m;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [20:0] jraw;
    int          iimm;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    m = "ILLEGAL";
    if (opc == 7'h33 && f7 == 7'h00) begin
      if (f3 == 0) m = "ADD";
      if (f3 == 7) m = "AND";
      if (f3 == 6) m = "OR";
      if (f3 == 4) m = "XOR";
      if (f3 == 1) m = "SLL";
      if (f3 == 5) m = "SRL";
    end
    if (opc == 7'h33 && f7 == 7'h20 && f3 == 0) m = "SUB";
    if (opc == 7'h13 && f3 == 0) m = "ADDI";
    if (opc == 7'h13 && f3 == 1 && f7 == 0) m = "SLLI";
    if (opc == 7'h13 && f3 == 5 && f7 == 0) m = "SRLI";
    if (opc == 7'h37) m = "LUI";
    if (opc == 7'h17) m = "AUIPC";
    if (opc == 7'h6F) m = "JAL";
    if (opc == 7'h67 && f3 == 0) m = "JALR";

    b = '0;
    b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7]; b.pc = pc;
    iimm = int'(w) >>> 20;
    jraw = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    b.rw = 1'b1; b.op2 = 1'b1; b.op1 = 2'd0;
    case (m)
      "ADD":   begin b.alu_sel = 0; b.op2 = 0; end
      "SUB":   begin b.alu_sel = 1; b.op2 = 0; end
      "AND":   begin b.alu_sel = 2; b.op2 = 0; end
      "OR":    begin b.alu_sel = 3; b.op2 = 0; end
      "XOR":   begin b.alu_sel = 4; b.op2 = 0; end
      "SLL":   begin b.alu_sel = 5; b.op2 = 0; end
      "SRL":   begin b.alu_sel = 6; b.op2 = 0; end
      "ADDI":  begin b.alu_sel = 7;  b.imm = iimm; end
      "SLLI":  begin b.alu_sel = 8;  b.imm = 32'(w[24:20]); end
      "SRLI":  begin b.alu_sel = 9;  b.imm = 32'(w[24:20]); end
      "LUI":   begin b.alu_sel = 10; b.op1 = 2; b.imm = w & 32'hFFFFF000; end
      "AUIPC": begin b.alu_sel = 11; b.op1 = 1; b.imm = w & 32'hFFFFF000; end
      "JAL":   begin b.alu_sel = 12; b.op1 = 1;
                     b.imm = jraw[20] ? (32'(jraw) - 32'h0020_0000) : 32'(jraw); end
      "JALR":  begin b.alu_sel = 13; b.imm = iimm; end
      default: begin b.ill = 1; b.rw = 0; b.op2 = 0; end
    endcase
    if (b.rd == 0) b.rw = 1'b0;
    return b;
  endfunction

  // One clock with scoreboard and hold-stability bookkeeping.
  task automatic cycle();
    logic    inf, outf, held;
    bundle_t got;
    inf  = in_valid && in_ready;
    outf = out_valid && out_ready;
    got  = cur_out();
    held = out_valid && !out_ready;
    if (outf) begin
      n_out++;
      m_dec = m_dec + 1;
      if (got.ill) m_ill = m_ill + 1;
      if (exp_q.size() == 0) check("sb_unexpected_out", 128'(out_valid), 128'(0));
      else check("sb_bundle", 128'(got), 128'(exp_q.pop_front()));
    end
    if (inf) exp_q.push_back(ref_decode(in_instr, in_pc));
    @(posedge clk);
    #1;
    if (held) check("hold_stable", 128'({out_valid, cur_out()}), 128'({1'b1, got}));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_dec = 0;
    m_ill = 0;
  endtask

  task automatic send(logic [31:0] w, logic [31:0] pc);
    in_valid = 1'b1; in_instr = w; in_pc = pc; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain(int budget);
    int k;
    in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while ((out_valid || exp_q.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    check("drain_in_budget", 128'(out_valid), 128'(0));
  endtask

  function automatic logic [31:0] addi_x(int n);
    logic [11:0] imm;
    logic [4:0]  rd;
    imm = 12'(n); rd = 5'(n);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  initial begin
    logic [6:0] opcs [9];
    logic [31:0] w;
    int idx, k, n0;

    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_bundle_zero", 128'(cur_out()), 128'(0));

    // SUB x1, x1, x2
    send(32'h402080B3, 32'h0);
    check("sub_valid", 128'(out_valid), 128'(1));
    check("sub_alu_sel", 128'(out_alu_sel), 128'(4'b0001));
    check("sub_op2", 128'(out_op2_sel), 128'(0));
    check("sub_regs", 128'({out_rd, out_rs1, out_rs2}), 128'({5'd1, 5'd1, 5'd2}));
    check("sub_rw", 128'(out_reg_write), 128'(1));

    send(32'h123450B7, 32'h100);
    check("lui_alu_sel", 128'(out_alu_sel), 128'(4'b1010));
    check("lui_imm", 128'(out_imm), 128'(32'h12345000));
    check("lui_op1", 128'(out_op1_sel), 128'(2));

    send(32'hFFFFF097, 32'h104);
    check("auipc_alu_sel", 128'(out_alu_sel), 128'(4'b1011));
    check("auipc_imm", 128'(out_imm), 128'(32'hFFFFF000));
    check("auipc_op1", 128'(out_op1_sel), 128'(1));
    check("auipc_pc", 128'(out_pc), 128'(32'h104));

    send(32'hFF5FF0EF, 32'h108);
    check("jal_alu_sel", 128'(out_alu_sel), 128'(4'b1100));
    check("jal_imm", 128'(out_imm), 128'(32'hFFFFFFF4));
    check("jal_op1", 128'(out_op1_sel), 128'(1));

    send(32'h4030D093, 32'h10C);
    check("srai_illegal", 128'(out_illegal), 128'(1));
    check("srai_alu_sel", 128'(out_alu_sel), 128'(0));
    check("srai_rw", 128'(out_reg_write), 128'(0));
    check("srai_imm", 128'(out_imm), 128'(0));

    // rd = 0 suppresses the write even for a legal ADD.
    send(32'h00208033, 32'h110);
    check("rd0_rw", 128'(out_reg_write), 128'(0));
    drain(10);

    // Backpressure: ADDI x1..x4 with out_ready low for three cycles.
    n0 = n_out;
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200;
    in_instr = addi_x(1); cycle();
    check("bp_ready_after_1", 128'(in_ready), 128'(1));
    in_instr = addi_x(2); cycle();
    check("bp_ready_after_2", 128'(in_ready), 128'(0));
    in_instr = addi_x(3); cycle();
    check("bp_hold_rd", 128'({out_valid, out_rd}), 128'({1'b1, 5'd1}));
    check("bp_still_blocked", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    idx = 3; k = 0;
    while (idx <= 4 && k < 20) begin
      in_instr = addi_x(idx);
      if (in_ready) idx++;
      cycle();
      k++;
    end
    drain(20);
    check("bp_out_count", 128'(n_out - n0), 128'(4));

    // Reset with both entries occupied.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = addi_x(5); cycle();
    in_instr = addi_x(6); cycle();
    check("full_before_reset", 128'({out_valid, in_ready}), 128'({1'b1, 1'b0}));
    in_valid = 1'b0;
    do_reset();
    check("rst_mid_out_valid", 128'(out_valid), 128'(0));
    check("rst_mid_in_ready", 128'(in_ready), 128'(1));
    send(32'h00708393, 32'h300);   // addi x7, x1, 7
    check("post_rst_alu_sel", 128'(out_alu_sel), 128'(4'b0111));
    check("post_rst_rd", 128'({out_rd, out_imm}), 128'({5'd7, 32'd7}));
    drain(10);

    // Random stream with random valid/ready.
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !in_ready)) begin
        w = $urandom;
        w[6:0] = opcs[$urandom_range(0, 8)];
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: ;
        endcase
        in_instr = w;
        in_pc    = $urandom;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain(20);
    check("sb_empty_end", 128'(exp_q.size()), 128'(0));
`ifdef ALU_DECODE_PERF_EN
    check("perf_decoded", 128'(perf_decoded), 128'(m_dec));
    check("perf_illegal", 128'(perf_illegal), 128'(m_ill));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
